// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: command port in, classic/incrementing bursts out.
// Optional macro WB_MASTER_TIMEOUT_EN adds a no-response abort after TIMEOUT_CYCLES.
//
// Ports:
//   wb_clk_i, wb_rst_ni                : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o            : command handshake (we, adr, len, bte)
//   wr_valid_i/wr_ready_o/wr_data_i    : write-data stream in
//   rd_valid_o/rd_data_o               : read-data stream out (no backpressure)
//   done_o/err_o                       : completion pulse, err_o = aborted
//   wb_*                               : Wishbone B3 master bus
module wb_burst_master #(
    parameter int dw = 32,
    parameter int aw = 32
`ifdef WB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [3:0]    cmd_len_i,
    input  logic [1:0]    cmd_bte_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [dw-1:0] wr_data_i,
    output logic          rd_valid_o,
    output logic [dw-1:0] rd_data_o,
    output logic          done_o,
    output logic          err_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    typedef enum logic [1:0] {IDLE, FETCH, BUS, DONE} state_t;

    state_t        state_q;
    logic [4:0]    beats_q;
    logic          cyc_q, stb_q, we_q;
    logic          rd_valid_q, done_q, err_q;
    logic [aw-1:0] adr_q;
    logic [dw-1:0] dat_q, rd_data_q;
    logic [2:0]    cti_q;
    logic [1:0]    bte_q;

    logic          tmo_hit;
    logic          last_d, abort_d, ack_d;
    logic [4:0]    beats_d;
    logic [2:0]    cti_d;
    logic [aw-1:0] adr_d;

    // Wrapping bursts only step the low word-index bits of the address.
    function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] a,
                                               input logic [1:0]    b);
        logic [aw-1:0] r;
        r = a;
        case (b)
            2'b00:   r = a + aw'(4);
            2'b01:   r[3:2] = a[3:2] + 2'd1;
            2'b10:   r[4:2] = a[4:2] + 3'd1;
            default: r[5:2] = a[5:2] + 4'd1;
        endcase
        return r;
    endfunction

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW  = (TCW > 8) ? TCW : 8;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || !stb_q || wb_ack_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Fires on the edge where the count would reach TIMEOUT_CYCLES.
    assign tmo_hit = stb_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // err/rty/timeout take priority over a coincident ack.
    assign abort_d = stb_q & (wb_err_i | wb_rty_i | tmo_hit);
    assign ack_d   = stb_q & wb_ack_i & ~abort_d;
    assign last_d  = (beats_q == 5'd1);
    assign beats_d = beats_q - 5'd1;
    assign cti_d   = (beats_d == 5'd1) ? 3'b111 : 3'b010;
    assign adr_d   = next_adr(adr_q, bte_q);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            beats_q    <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rd_data_q  <= '0;
            cti_q      <= '0;
            bte_q      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        adr_q   <= cmd_adr_i & {{(aw-2){1'b1}}, 2'b00};
                        bte_q   <= cmd_bte_i;
                        we_q    <= cmd_we_i;
                        beats_q <= {1'b0, cmd_len_i} + 5'd1;
                        cti_q   <= (cmd_len_i == 4'd0) ? 3'b000 : 3'b010;
                        if (cmd_we_i) begin
                            state_q <= FETCH;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            state_q <= BUS;
                        end
                    end
                end
                FETCH: begin
                    if (wr_valid_i) begin
                        dat_q   <= wr_data_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (abort_d) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (ack_d) begin
                        adr_q   <= adr_d;
                        beats_q <= beats_d;
                        if (!we_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= wb_dat_i;
                        end
                        if (last_d) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cti_q <= cti_d;
                            if (we_q) begin
                                if (wr_valid_i) begin
                                    dat_q <= wr_data_i;
                                end else begin
                                    stb_q   <= 1'b0;
                                    state_q <= FETCH;
                                end
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign wr_ready_o  = (state_q == FETCH) ||
                         ((state_q == BUS) && we_q && ack_d && !last_d);
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = 4'hf;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_cti_o    = cti_q;
    assign wb_bte_o    = bte_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: memory slave, write-data source, scoreboard.
// Expected beats/reads/completions are derived from a word-address model.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [3:0]  cmd_len_i = '0;
    logic [1:0]  cmd_bte_i = '0;
    logic        wr_valid_i = 1'b0, wr_ready_o;
    logic [31:0] wr_data_i = '0;
    logic        rd_valid_o, done_o, err_o;
    logic [31:0] rd_data_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

    always #5 clk = ~clk;

    wb_burst_master dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
        .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .done_o(done_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic [31:0] dat;
        int          dly;
    } wword_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    bit          exp_done[$];
    wword_t      wq[$];

    logic [31:0] slave_mem[256];
    logic [31:0] ref_mem[256];

    int total = 0;
    int bad = 0;

    int err_beat = -1;
    bit use_rty = 1'b0;
    bit never_ack = 1'b0;
    int wait_pct = 0;
    int maxd = 0;

    int beat_idx = 0;
    bit in_cycle = 1'b0;
    int stb_cnt = 0;
    int stall_cnt = 0;
    int wr_wait = 0;
    bit prev_pend = 1'b0;
    logic [31:0] prev_adr, prev_dat;
    logic [2:0]  prev_cti;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected by the model", name);
    endfunction

    // Byte address of beat i: linear, or wrapping inside a k-word block.
    function automatic logic [31:0] model_adr(logic [31:0] base,
                                              logic [1:0] bte, int i);
        int k;
        int off;
        logic [31:0] blk;
        if (bte == 2'b00) return base + 32'(4 * i);
        k = 4 << (int'(bte) - 1);
        blk = base & ~(32'(k * 4) - 32'd1);
        off = (int'(base[5:2]) + i) % k;
        return blk + 32'(off * 4);
    endfunction

    // Slave, bus-beat checker and write-data source.
    always @(negedge clk) begin
        beat_t e;
        logic [7:0] idx;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = $urandom;
        if (!rst_n) begin
            prev_pend = 1'b0;
            in_cycle = 1'b0;
            beat_idx = 0;
            wr_valid_i = 1'b0;
        end else begin
            if (prev_pend) begin
                check("hold_stb", 64'(wb_stb_o), 64'd1);
                check("hold_adr", 64'(wb_adr_o), 64'(prev_adr));
                check("hold_cti", 64'(wb_cti_o), 64'(prev_cti));
                if (wb_we_o) check("hold_dat", 64'(wb_dat_o), 64'(prev_dat));
            end
            if (wb_stb_o) begin
                in_cycle = 1'b1;
                stb_cnt++;
            end
            if (done_o) begin
                check("cyc_drop_at_done", 64'(wb_cyc_o), 64'd0);
                in_cycle = 1'b0;
            end else if (in_cycle) begin
                check("cyc_held", 64'(wb_cyc_o), 64'd1);
            end
            if (wb_cyc_o && !wb_stb_o) stall_cnt++;
            if (!wb_cyc_o) beat_idx = 0;
            prev_pend = 1'b0;
            prev_adr = wb_adr_o;
            prev_dat = wb_dat_o;
            prev_cti = wb_cti_o;
            if (wb_stb_o) begin
                if (never_ack || ($urandom_range(99) < wait_pct)) begin
                    prev_pend = 1'b1;
                end else begin
                    idx = wb_adr_o[9:2];
                    if (beat_idx == err_beat) begin
                        if (use_rty) wb_rty_i = 1'b1;
                        else begin
                            wb_err_i = 1'b1;
                            wb_ack_i = 1'b1;
                        end
                    end else begin
                        wb_ack_i = 1'b1;
                        if (wb_we_o) slave_mem[idx] = wb_dat_o;
                        else wb_dat_i = slave_mem[idx];
                    end
                    if (exp_beats.size() == 0) begin
                        fail("beat_unexpected");
                    end else begin
                        e = exp_beats.pop_front();
                        check("beat_adr", 64'(wb_adr_o), 64'(e.adr));
                        check("beat_cti", 64'(wb_cti_o), 64'(e.cti));
                        check("beat_bte", 64'(wb_bte_o), 64'(e.bte));
                        check("beat_we", 64'(wb_we_o), 64'(e.we));
                        check("beat_sel", 64'(wb_sel_o), 64'hf);
                        if (e.we) check("beat_dat", 64'(wb_dat_o), 64'(e.dat));
                    end
                    beat_idx++;
                end
            end
            wr_valid_i = 1'b0;
            if (wq.size() > 0) begin
                if (wr_wait >= wq[0].dly) begin
                    wr_valid_i = 1'b1;
                    wr_data_i = wq[0].dat;
                end else begin
                    wr_wait++;
                end
            end
            #1;
            if (wr_valid_i && wr_ready_o) begin
                void'(wq.pop_front());
                wr_wait = 0;
            end
        end
    end

    // Scoreboard monitor for the local read stream and completion.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid_o) begin
                if (exp_rd.size() == 0) fail("rd_unexpected");
                else check("rd_data", 64'(rd_data_o), 64'(exp_rd.pop_front()));
            end
            if (done_o) begin
                if (exp_done.size() == 0) fail("done_unexpected");
                else check("done_err", 64'(err_o), 64'(exp_done.pop_front()));
            end
        end
    end

    task automatic send_cmd(input bit we, input logic [31:0] adr,
                            input int len, input logic [1:0] bte);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready_o) fail("cmd_ready_timeout");
        stb_cnt = 0;
        stall_cnt = 0;
        cmd_we_i = we;
        cmd_adr_i = adr;
        cmd_len_i = 4'(len);
        cmd_bte_i = bte;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_done.size() != 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (exp_done.size() != 0) begin
            fail("done_timeout");
            exp_done.delete();
            exp_beats.delete();
            exp_rd.delete();
            wq.delete();
        end
        @(negedge clk);
        check("beats_left_over", 64'(exp_beats.size()), 64'd0);
        check("rd_left_over", 64'(exp_rd.size()), 64'd0);
        check("wr_words_left", 64'(wq.size()), 64'd0);
    endtask

    task automatic run_cmd(input bit we, input logic [31:0] adr, input int len,
                           input logic [1:0] bte, input int errb,
                           input bit rty, input int stall_at,
                           input logic [31:0] fix_base);
        int n;
        bit aborted;
        beat_t b;
        wword_t w;
        logic [7:0] idx;
        aborted = (errb >= 0) && (errb <= len);
        n = aborted ? errb + 1 : len + 1;
        for (int i = 0; i < n; i++) begin
            b.adr = model_adr(adr & 32'hffff_fffc, bte, i);
            b.cti = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
            b.bte = bte;
            b.we = we;
            b.dat = '0;
            if (we) b.dat = (fix_base != 0) ? fix_base + 32'(i) : $urandom;
            exp_beats.push_back(b);
            idx = b.adr[9:2];
            if (!(aborted && i == errb)) begin
                if (we) ref_mem[idx] = b.dat;
                else exp_rd.push_back(ref_mem[idx]);
            end
            if (we) begin
                w.dat = b.dat;
                w.dly = (i == stall_at) ? 3 : $urandom_range(maxd);
                wq.push_back(w);
            end
        end
        exp_done.push_back(aborted);
        err_beat = errb;
        use_rty = rty;
        send_cmd(we, adr, len, bte);
        wait_done();
        err_beat = -1;
    endtask

    initial begin
        int diff;
        bit rwe;
        int rlen;
        int rerr;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i] = slave_mem[i];
        end
        slave_mem[16] = 32'h1234_5678;
        ref_mem[16] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb_stb_o), 64'd0);
        check("rst_we", 64'(wb_we_o), 64'd0);
        check("rst_adr", 64'(wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        check("rst_cti", 64'(wb_cti_o), 64'd0);
        check("rst_bte", 64'(wb_bte_o), 64'd0);
        check("rst_outs", 64'({rd_valid_o, done_o, err_o, wr_ready_o}), 64'd0);
        rst_n = 1'b1;

        run_cmd(1'b0, 32'h40, 0, 2'b00, -1, 1'b0, -1, 32'h0);
        run_cmd(1'b1, 32'h100, 3, 2'b00, -1, 1'b0, -1, 32'hA0);
        check("mem_wr0", 64'(slave_mem[64]), 64'hA0);
        check("mem_wr3", 64'(slave_mem[67]), 64'hA3);
        run_cmd(1'b0, 32'h100, 3, 2'b00, -1, 1'b0, -1, 32'h0);
        run_cmd(1'b0, 32'h18, 3, 2'b01, -1, 1'b0, -1, 32'h0);
        check("b2b_stb_cycles", 64'(stb_cnt), 64'd4);
        run_cmd(1'b1, 32'h200, 3, 2'b00, -1, 1'b0, 2, 32'h0);
        check("fetch_stall_cycles", 64'(stall_cnt), 64'd3);
        run_cmd(1'b0, 32'h80, 7, 2'b00, 2, 1'b0, -1, 32'h0);
        run_cmd(1'b1, 32'h300, 5, 2'b10, 1, 1'b1, -1, 32'h0);
        run_cmd(1'b0, 32'h3c8, 15, 2'b11, -1, 1'b0, -1, 32'h0);

        wait_pct = 30;
        maxd = 2;
        for (int n = 0; n < 60; n++) begin
            rwe = 1'($urandom_range(1));
            rlen = $urandom_range(15);
            rerr = ($urandom_range(5) == 0) ? $urandom_range(rlen) : -1;
            run_cmd(rwe, 32'($urandom_range(1023)), rlen,
                    2'($urandom_range(3)), rerr, 1'($urandom_range(1)),
                    -1, 32'h0);
        end
        wait_pct = 0;
        maxd = 0;

        diff = 0;
        for (int i = 0; i < 256; i++)
            if (slave_mem[i] !== ref_mem[i]) diff++;
        check("mem_final_diffs", 64'(diff), 64'd0);

        never_ack = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
        exp_done.push_back(1'b1);
        send_cmd(1'b0, 32'h20, 0, 2'b00);
        wait_done();
        check("timeout_stb_cycles", 64'(stb_cnt), 64'd255);
        send_cmd(1'b0, 32'h20, 0, 2'b00);
        repeat (50) @(negedge clk);
`else
        send_cmd(1'b0, 32'h20, 0, 2'b00);
        repeat (1000) @(negedge clk);
`endif
        check("no_ack_stb_held", 64'(wb_stb_o), 64'd1);
        check("no_ack_cyc_held", 64'(wb_cyc_o), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cyc", 64'(wb_cyc_o), 64'd0);
        check("midrst_stb", 64'(wb_stb_o), 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        check("midrst_ready", 64'(cmd_ready_o), 64'd1);
        never_ack = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 64'(exp_done.size()), 64'd0);
        run_cmd(1'b0, 32'h100, 1, 2'b00, -1, 1'b0, -1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
